// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network blocks: readout FSM states,
// width helpers and the default decoding window length.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int SPIKE_WINDOW_DEFAULT = 16;

    // Bits needed to hold every value 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_readout_if.sv
// Result channel of spike_readout: valid/ready handshake carrying the winner
// and the per-neuron spike counts of one decoding window.
interface spike_readout_if #(
    parameter int NEURONS    = 8,
    parameter int COUNT_BITS = 5,
    parameter int IDX_BITS   = 3
);
    logic                          out_valid;
    logic                          out_ready;
    logic [IDX_BITS-1:0]           out_winner;
    logic [COUNT_BITS-1:0]         out_count;
    logic                          out_none;
    logic [NEURONS*COUNT_BITS-1:0] out_counts;

    modport master (
        output out_valid, out_winner, out_count, out_none, out_counts,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_winner, out_count, out_none, out_counts,
        output out_ready
    );
endinterface

// File: rtl/spike_counter.sv
// One readout channel: saturating spike count plus the step of the first spike
// seen in the window (TIMESTEPS means "never spiked").
module spike_counter #(
    parameter int TIMESTEPS  = 16,
    parameter int COUNT_BITS = 5,
    parameter int STEP_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  sample,
    input  logic [STEP_BITS-1:0]  step,
    output logic [COUNT_BITS-1:0] count,
    output logic [STEP_BITS-1:0]  stamp
);
    localparam logic [STEP_BITS-1:0]  NO_SPIKE  = STEP_BITS'(TIMESTEPS);
    localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            stamp <= NO_SPIKE;
        end else if (clear) begin
            count <= '0;
            stamp <= NO_SPIKE;
        end else if (sample) begin
            if (count != COUNT_MAX) begin
                count <= count + COUNT_BITS'(1);
            end
            if (stamp == NO_SPIKE) begin
                stamp <= step;
            end
        end
    end
endmodule

// File: rtl/spike_readout.sv
// Rate decoder for a neuron layer: counts spikes over a window, scans for the
// neuron with the most (earliest first spike breaks ties) and hands it out.
module spike_readout
    import snn_pkg::*;
#(
    parameter int NEURONS    = 8,
    parameter int TIMESTEPS  = SPIKE_WINDOW_DEFAULT,
    parameter int COUNT_BITS = count_width(TIMESTEPS),
    parameter int IDX_BITS   = idx_width(NEURONS),
    parameter int STEP_BITS  = count_width(TIMESTEPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               enable,
    input  logic [NEURONS-1:0] spikes,
    output logic               busy,
    spike_readout_if.master    res
);
    state_t state, state_next;

    logic [STEP_BITS-1:0]  step;
    logic [IDX_BITS-1:0]   scan_idx;
    logic [IDX_BITS-1:0]   best_idx;
    logic [COUNT_BITS-1:0] best_count;
    logic [STEP_BITS-1:0]  best_stamp;

    logic                  valid;
    logic [IDX_BITS-1:0]   winner;
    logic [COUNT_BITS-1:0] win_count;
    logic                  none;

    logic [COUNT_BITS-1:0] count [NEURONS];
    logic [STEP_BITS-1:0]  stamp [NEURONS];

    logic clear, step_en, last_step, last_scan;

    assign clear     = (state == IDLE) && start;
    assign step_en   = (state == ACCUM) && enable;
    assign last_step = step_en && (step == STEP_BITS'(TIMESTEPS - 1));
    assign last_scan = (state == SCAN) && (scan_idx == IDX_BITS'(NEURONS - 1));

    for (genvar i = 0; i < NEURONS; i++) begin : g_ch
        spike_counter #(
            .TIMESTEPS (TIMESTEPS),
            .COUNT_BITS(COUNT_BITS),
            .STEP_BITS (STEP_BITS)
        ) u_counter (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .sample(step_en && spikes[i]),
            .step  (step),
            .count (count[i]),
            .stamp (stamp[i])
        );
    end

    // Scan comparator: the candidate wins on a higher count, or on an equal
    // count with an earlier first spike; neuron 0 always seeds the search.
    logic [COUNT_BITS-1:0] cand_count;
    logic [STEP_BITS-1:0]  cand_stamp;
    logic                  take;
    logic [IDX_BITS-1:0]   next_idx;
    logic [COUNT_BITS-1:0] next_count;
    logic [STEP_BITS-1:0]  next_stamp;

    assign cand_count = count[scan_idx];
    assign cand_stamp = stamp[scan_idx];
    assign take = (scan_idx == '0)
               || (cand_count > best_count)
               || ((cand_count == best_count) && (cand_stamp < best_stamp));
    assign next_idx   = take ? scan_idx   : best_idx;
    assign next_count = take ? cand_count : best_count;
    assign next_stamp = take ? cand_stamp : best_stamp;

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)                   state_next = ACCUM;
            ACCUM:   if (last_step)               state_next = SCAN;
            SCAN:    if (last_scan)               state_next = HOLD;
            HOLD:    if (valid && res.out_ready)  state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step       <= '0;
            scan_idx   <= '0;
            best_idx   <= '0;
            best_count <= '0;
            best_stamp <= '0;
            winner     <= '0;
            win_count  <= '0;
            none       <= 1'b0;
            valid      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= (state_next == HOLD);
            busy  <= (state_next != IDLE);
            if (clear) begin
                step <= '0;
            end
            if (step_en) begin
                step <= step + STEP_BITS'(1);
            end
            if (last_step) begin
                scan_idx <= '0;
            end
            if (state == SCAN) begin
                scan_idx   <= scan_idx + IDX_BITS'(1);
                best_idx   <= next_idx;
                best_count <= next_count;
                best_stamp <= next_stamp;
            end
            // The best count is the maximum, so zero here means no neuron spiked.
            if (last_scan) begin
                none      <= (next_count == '0);
                winner    <= (next_count == '0) ? '0 : next_idx;
                win_count <= next_count;
            end
        end
    end

    always_comb begin
        res.out_counts = '0;
        for (int i = 0; i < NEURONS; i++) begin
            res.out_counts[i*COUNT_BITS +: COUNT_BITS] = count[i];
        end
    end

    assign res.out_valid  = valid;
    assign res.out_winner = winner;
    assign res.out_count  = win_count;
    assign res.out_none   = none;
endmodule

// File: tb/tb_spike_readout.sv
// Scoreboard bench for spike_readout: a full-width instance and a 3-bit
// saturating instance share the stimulus; a reference model predicts both.
module tb_spike_readout;
    import snn_pkg::*;

    localparam int NEURONS   = 8;
    localparam int TIMESTEPS = SPIKE_WINDOW_DEFAULT;
    localparam int CB        = 5;
    localparam int SAT_CB    = 3;
    localparam int IDX       = 3;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               enable;
    logic [NEURONS-1:0] spikes;
    logic               busy;
    logic               busy_sat;

    spike_readout_if #(.NEURONS(NEURONS), .COUNT_BITS(CB),     .IDX_BITS(IDX)) res ();
    spike_readout_if #(.NEURONS(NEURONS), .COUNT_BITS(SAT_CB), .IDX_BITS(IDX)) res_sat ();

    spike_readout #(.NEURONS(NEURONS), .TIMESTEPS(TIMESTEPS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .enable(enable),
        .spikes(spikes), .busy(busy), .res(res)
    );

    spike_readout #(.NEURONS(NEURONS), .TIMESTEPS(TIMESTEPS), .COUNT_BITS(SAT_CB)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .enable(enable),
        .spikes(spikes), .busy(busy_sat), .res(res_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          winner;
        int          count;
        bit          none;
        logic [63:0] counts;
    } exp_t;

    exp_t q_main[$];
    exp_t q_sat[$];
    int   checks = 0;
    int   errors = 0;

    bit [NEURONS-1:0] pat [TIMESTEPS];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference decoder working straight from the spike pattern.
    function automatic exp_t model(input int cbits);
        int   cnt [NEURONS];
        int   stp [NEURONS];
        int   maxc;
        int   best;
        exp_t e;
        maxc = (1 << cbits) - 1;
        for (int i = 0; i < NEURONS; i++) begin
            cnt[i] = 0;
            stp[i] = TIMESTEPS;
        end
        for (int s = 0; s < TIMESTEPS; s++) begin
            for (int i = 0; i < NEURONS; i++) begin
                if (pat[s][i]) begin
                    if (cnt[i] < maxc) cnt[i]++;
                    if (stp[i] == TIMESTEPS) stp[i] = s;
                end
            end
        end
        best = 0;
        for (int i = 1; i < NEURONS; i++) begin
            if (cnt[i] > cnt[best] || (cnt[i] == cnt[best] && stp[i] < stp[best])) best = i;
        end
        e.none   = (cnt[best] == 0);
        e.winner = e.none ? 0 : best;
        e.count  = e.none ? 0 : cnt[best];
        e.counts = '0;
        for (int i = 0; i < NEURONS; i++) begin
            e.counts = e.counts | (64'(cnt[i]) << (i * cbits));
        end
        return e;
    endfunction

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (rst_n && res.out_valid && res.out_ready) begin
            if (q_main.size() == 0) begin
                check("main_unexpected_result", 1, 0);
            end else begin
                e = q_main.pop_front();
                check("main_winner", res.out_winner, e.winner);
                check("main_count",  res.out_count,  e.count);
                check("main_none",   res.out_none,   e.none);
                check("main_counts", res.out_counts, e.counts);
            end
        end
    end

    always @(negedge clk) begin : mon_sat
        exp_t e;
        if (rst_n && res_sat.out_valid && res_sat.out_ready) begin
            if (q_sat.size() == 0) begin
                check("sat_unexpected_result", 1, 0);
            end else begin
                e = q_sat.pop_front();
                check("sat_winner", res_sat.out_winner, e.winner);
                check("sat_count",  res_sat.out_count,  e.count);
                check("sat_none",   res_sat.out_none,   e.none);
                check("sat_counts", res_sat.out_counts, e.counts);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input bit v);
        res.out_ready     = v;
        res_sat.out_ready = v;
    endtask

    task automatic clear_pat();
        for (int s = 0; s < TIMESTEPS; s++) pat[s] = '0;
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_busy"},   {busy, busy_sat}, 0);
        check({tag, "_valid"},  {res.out_valid, res_sat.out_valid}, 0);
        check({tag, "_winner"}, res.out_winner, 0);
        check({tag, "_count"},  res.out_count, 0);
        check({tag, "_none"},   res.out_none, 0);
        check({tag, "_counts"}, res.out_counts, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic run_window(input int max_gap, input bit push, input bit wait_out, input bit noisy);
        int g;
        int n;
        do_start();
        for (int s = 0; s < TIMESTEPS; s++) begin
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) begin
                enable = 1'b0;
                spikes = NEURONS'($urandom);
                start  = noisy;
                tick();
            end
            enable = 1'b1;
            spikes = pat[s];
            start  = noisy;
            tick();
        end
        enable = 1'b0;
        spikes = '0;
        if (push) begin
            q_main.push_back(model(CB));
            q_sat.push_back(model(SAT_CB));
        end
        if (wait_out) begin
            n = 0;
            while (!res.out_valid && n < 40) begin
                tick();
                n++;
            end
            check("valid_latency", n, NEURONS);
        end
    endtask

    task automatic finish_window(input int stall, input bit noisy);
        logic [63:0] snap;
        int          n;
        start = noisy;
        if (stall > 0) begin
            set_ready(1'b0);
            snap = {res.out_winner, res.out_count, res.out_none, res.out_counts};
            repeat (stall) begin
                tick();
                check("stall_valid", res.out_valid, 1);
                check("stall_stable", {res.out_winner, res.out_count, res.out_none, res.out_counts}, snap);
            end
        end
        set_ready(1'b1);
        n = 0;
        while (res.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("valid_cycles_after_ready", n, 1);
        start = 1'b0;
        set_ready(1'b0);
        tick();
        check("idle_after_handshake", busy, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        enable = 1'b0;
        spikes = '0;
        set_ready(1'b0);
        #23;
        reset_values("reset");
        rst_n = 1'b1;
        tick();

        // Enables and spikes in IDLE are ignored.
        enable = 1'b1;
        spikes = '1;
        repeat (3) tick();
        enable = 1'b0;
        spikes = '0;
        check("idle_ignores_enable", {busy, res.out_counts}, 0);

        // Neuron 3 fires every step; ready already high before valid.
        clear_pat();
        for (int s = 0; s < TIMESTEPS; s++) pat[s][3] = 1'b1;
        set_ready(1'b1);
        run_window(0, 1, 1, 0);
        finish_window(0, 0);

        // Equal counts: neuron 5 spikes first, so it wins.
        clear_pat();
        pat[1][5] = 1'b1; pat[4][5] = 1'b1; pat[6][5] = 1'b1; pat[8][5] = 1'b1;
        pat[3][2] = 1'b1; pat[5][2] = 1'b1; pat[7][2] = 1'b1; pat[9][2] = 1'b1;
        pat[10][0] = 1'b1; pat[12][0] = 1'b1;
        run_window(0, 1, 1, 0);
        finish_window(0, 0);

        // Equal counts and stamps: lower index keeps it.
        clear_pat();
        for (int k = 3; k <= 9; k += 2) begin
            pat[k][2] = 1'b1;
            pat[k][5] = 1'b1;
        end
        run_window(0, 1, 1, 0);
        finish_window(0, 0);

        // Silent window.
        clear_pat();
        run_window(1, 1, 1, 0);
        finish_window(0, 0);

        // Saturation in the narrow instance, with random enable gaps.
        clear_pat();
        for (int s = 0; s < TIMESTEPS; s++) pat[s][0] = 1'b1;
        for (int s = 2; s < 12; s++) pat[s][6] = 1'b1;
        run_window(5, 1, 1, 0);
        finish_window(0, 0);

        // Random window, stalled handshake, start pulsed in every busy phase.
        for (int s = 0; s < TIMESTEPS; s++) pat[s] = NEURONS'($urandom);
        run_window(3, 1, 1, 1);
        finish_window(10, 1);

        // Fresh window after the ignored starts begins with cleared counts.
        for (int s = 0; s < TIMESTEPS; s++) pat[s] = NEURONS'($urandom) & NEURONS'($urandom);
        run_window(2, 1, 1, 0);
        finish_window(3, 0);

        // Reset in the middle of ACCUM.
        for (int s = 0; s < TIMESTEPS; s++) pat[s] = '1;
        do_start();
        for (int s = 0; s < 7; s++) begin
            enable = 1'b1;
            spikes = pat[s];
            tick();
        end
        enable = 1'b0;
        rst_n  = 1'b0;
        #1;
        reset_values("rst_accum");
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_accum_idle", busy, 0);

        // Reset in the middle of SCAN.
        run_window(0, 0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        reset_values("rst_scan");
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_scan_idle", busy, 0);

        // Result after reset comes from cleared counts.
        clear_pat();
        pat[0][7] = 1'b1; pat[5][7] = 1'b1; pat[6][1] = 1'b1;
        run_window(1, 1, 1, 0);
        finish_window(0, 0);

        repeat (2) tick();
        check("main_queue_drained", q_main.size(), 0);
        check("sat_queue_drained", q_sat.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spike_readout.md
# spike_readout

Output-side decoder for a layer of `neuron_lif` instances. It consumes their per-timestep `is_spike` outputs over a fixed window and rate-decodes them into spike counts per neuron. It then selects a winning neuron and presents the result on a valid/ready handshake. The block sits between the neuron array and the host or next layer, turning spike trains back into a classification value.

## Interface
- `NEURONS`, 8: number of spike channels (≥2).
- `TIMESTEPS`, 16: timesteps per decoding window (≥1).
- `COUNT_BITS`, `$clog2(TIMESTEPS+1)`: per-neuron counter width; may be set smaller, in which case counters saturate.
- `IDX_BITS`, `$clog2(NEURONS)`: winner index width.
- `STEP_BITS`, `$clog2(TIMESTEPS+1)`: timestep and first-spike timestamp width.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: begin a window; accepted only in IDLE.
- `enable`  in  1: timestep strobe, the same signal that clocks the neuron array's `enable`.
- `spikes`  in  NEURONS: `is_spike` of each neuron, sampled when `enable` is high.
- `busy`  out  1: high in ACCUM, SCAN and HOLD.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer accepts the result.
- `out_winner`  out  IDX_BITS: index of the winning neuron.
- `out_count`  out  COUNT_BITS: spike count of the winner.
- `out_none`  out  1: no neuron spiked in the window.
- `out_counts`  out  NEURONS*COUNT_BITS: all counts; neuron i occupies bits [i*COUNT_BITS +: COUNT_BITS].

## Operation
- Reset values:
  - State is IDLE.
  - All counts are 0; all first-spike stamps are TIMESTEPS.
  - `busy`, `out_valid`, `out_winner`, `out_count` and `out_none` are all 0.
- IDLE, when `start` is high:
  - Clear counts to 0, first-spike stamps to TIMESTEPS, and the step counter to 0.
  - Go to ACCUM.
  - `enable` and `spikes` are ignored while in IDLE.
- ACCUM, on each cycle with `enable` high:
  - For every i with `spikes[i]` high, `count[i]` increments, saturating at 2^COUNT_BITS-1.
  - If `stamp[i]` equals TIMESTEPS, it is set to the current step.
  - The step counter increments.
  - The enable that carries step TIMESTEPS-1 moves the FSM to SCAN with scan index 0.
  - Cycles with `enable` low change nothing.
- SCAN: one neuron is compared per cycle, in index order 0..NEURONS-1.
  - Neuron 0 initialises the best candidate.
  - Neuron i replaces the best if its count is strictly greater.
  - On an equal count, it replaces the best only if its stamp is strictly smaller (earlier first spike).
  - A remaining tie keeps the lower index.
  - After index NEURONS-1, the FSM registers the results and goes to HOLD.
- HOLD:
  - `out_valid` is 1 and all `out_*` signals are stable.
  - `out_none` is 1 iff every count is 0; in that case `out_winner` and `out_count` are 0.
  - When `out_valid` and `out_ready` are both high, the FSM goes to IDLE and `out_valid` drops.
  - `out_counts` keeps its value until the next `start`.
- `start` outside IDLE is ignored. A `start` in the same cycle as the HOLD handshake is also ignored; it must be reasserted in IDLE.
- Arithmetic is unsigned throughout. Neither the step counter nor the counts can wrap.

## Timing
- `busy` rises on the clock edge after `start` is accepted.
- `out_valid` rises exactly NEURONS clock edges after the edge that sampled the final `enable`.
- End-to-end latency is TIMESTEPS enabled cycles plus NEURONS cycles, plus any handshake stall.
- `out_ready` may be high before `out_valid`. In that case the handshake completes in the first HOLD cycle, so `out_valid` is high for exactly one cycle.
- `rst_n` asserted mid-window or mid-scan returns everything to reset values immediately, with no output pulse.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `snn_pkg` holds:
  - the FSM state enum (IDLE, ACCUM, SCAN, HOLD);
  - the width helper functions;
  - a `SPIKE_WINDOW_DEFAULT` = 16 constant reused by the neuron layer's testbench.
- One sub-module, `spike_counter`: a single channel with a saturating count and a first-spike stamp register, instantiated NEURONS times with a generate loop.
- The scan comparator stays inline in `spike_readout`.

## Test plan
- Window with neuron 3 spiking every step, others silent (NEURONS=8, TIMESTEPS=16) -> `out_winner`=3, `out_count`=16, `out_none`=0; `out_valid` rises 8 edges after the 16th enable.
- Neurons 2 and 5 each spike 4 times; 5 first spikes at step 1, 2 first spikes at step 3 -> winner 5. Repeat with equal stamps -> winner 2.
- No spikes in the window -> `out_none`=1, `out_winner`=0, `out_count`=0, all `out_counts` 0.
- COUNT_BITS=3 with neuron 0 spiking 16 times -> count saturates at 7, winner 0. `enable` gaps of 0–5 cycles change neither the counts nor the step count.
- `out_ready` held low for 10 cycles -> outputs stable and `out_valid` held. A `start` pulsed during ACCUM, SCAN, HOLD and in the handshake cycle is ignored. Reassert `start` in IDLE -> a new window begins with counts cleared.
- `rst_n` asserted midway through ACCUM and again during SCAN -> all outputs 0 and state IDLE immediately. The next `start` produces a correct result from cleared counts.
